// File: rtl/control_filtro_param_if.sv
// Handshake and select bundle between the FIR sequencer and its neighbours.
// The master side raises sample requests and stalls; the slave side (the
// sequencer) drives the datapath selects and status pulses.
interface control_filtro_param_if #(
  parameter int SEL_W = 3
);
  logic             Bandera;
  logic [SEL_W:0]   n_taps;
  logic             hold;
  logic [SEL_W-1:0] sel_const;
  logic [1:0]       sel_fun;
  logic [1:0]       sel_acum;
  logic             SH_R;
  logic             Band_Listo;
  logic             busy;
  logic             overrun;

  modport master (
    output Bandera, n_taps, hold,
    input  sel_const, sel_fun, sel_acum, SH_R, Band_Listo, busy, overrun
  );

  modport slave (
    input  Bandera, n_taps, hold,
    output sel_const, sel_fun, sel_acum, SH_R, Band_Listo, busy, overrun
  );
endinterface

// File: rtl/control_filtro_param.sv
// FIR filter control sequencer: walks one tap per clock through the
// coefficient/function/accumulator selects, shifts the delay line and
// pulses Band_Listo when the filtered sample is valid. Tap count is a
// parameter, trimmed per pass by n_taps. All outputs are registered.
module control_filtro_param #(
  parameter int NTAPS = 5,
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  control_filtro_param_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FIRST = 3'd1;
  localparam logic [2:0] S_ACC   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [SEL_W:0]   N_MAX   = (SEL_W+1)'(NTAPS);
  localparam logic [SEL_W:0]   N_ONE   = (SEL_W+1)'(1);
  localparam logic [SEL_W-1:0] K_ZERO  = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] K_ONE   = SEL_W'(1);

  // A request of zero taps still runs one tap; requests beyond NTAPS are cut.
  function automatic logic [SEL_W:0] clamp_taps(input logic [SEL_W:0] req);
    logic [SEL_W:0] n;
    if (req == {(SEL_W+1){1'b0}}) begin
      n = N_ONE;
    end else if (req > N_MAX) begin
      n = N_MAX;
    end else begin
      n = req;
    end
    return n;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [SEL_W-1:0] k_q, k_d;
  logic [SEL_W:0]   n_q, n_d;
  logic             stall_s;

  logic [SEL_W-1:0] sel_const_q, sel_const_d;
  logic [1:0]       sel_fun_q, sel_fun_d;
  logic [1:0]       sel_acum_q, sel_acum_d;
  logic             sh_r_q, sh_r_d;
  logic             band_listo_q, band_listo_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  // Next state, tap counter, latched tap count and overrun detection.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    n_d       = n_q;
    stall_s   = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Bandera) begin
          state_d = S_FIRST;
          k_d     = K_ZERO;
          n_d     = clamp_taps(bus.n_taps);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FIRST: begin
        overrun_d = bus.Bandera;
        if (bus.hold) begin
          stall_s = 1'b1;
        end else if (n_q > N_ONE) begin
          state_d = S_ACC;
          k_d     = K_ONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ACC: begin
        overrun_d = bus.Bandera;
        if (bus.hold) begin
          stall_s = 1'b1;
        end else if ({1'b0, k_q} == (n_q - N_ONE)) begin
          state_d = S_SHIFT;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_SHIFT: begin
        overrun_d = bus.Bandera;
        if (bus.hold) begin
          stall_s = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.Bandera) begin
          state_d = S_FIRST;
          k_d     = K_ZERO;
          n_d     = clamp_taps(bus.n_taps);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = K_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state; a stalled cycle blocks accumulate and shift.
  always_comb begin
    sel_const_d  = K_ZERO;
    sel_fun_d    = 2'b00;
    sel_acum_d   = 2'b00;
    sh_r_d       = 1'b0;
    band_listo_d = 1'b0;
    busy_d       = 1'b0;
    case (state_d)
      S_FIRST: begin
        sel_const_d = k_d;
        sel_fun_d   = 2'b01;
        sel_acum_d  = stall_s ? 2'b00 : 2'b01;
        busy_d      = 1'b1;
      end
      S_ACC: begin
        sel_const_d = k_d;
        sel_fun_d   = 2'b10;
        sel_acum_d  = stall_s ? 2'b00 : 2'b10;
        busy_d      = 1'b1;
      end
      S_SHIFT: begin
        sh_r_d = ~stall_s;
        busy_d = 1'b1;
      end
      S_DONE: begin
        band_listo_d = 1'b1;
      end
      default: begin
        sel_const_d = K_ZERO;
      end
    endcase
  end

  // State and registered outputs; reset forces the idle picture at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= K_ZERO;
      n_q          <= N_ONE;
      sel_const_q  <= K_ZERO;
      sel_fun_q    <= 2'b00;
      sel_acum_q   <= 2'b00;
      sh_r_q       <= 1'b0;
      band_listo_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      n_q          <= n_d;
      sel_const_q  <= sel_const_d;
      sel_fun_q    <= sel_fun_d;
      sel_acum_q   <= sel_acum_d;
      sh_r_q       <= sh_r_d;
      band_listo_q <= band_listo_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.sel_const  = sel_const_q;
  assign bus.sel_fun    = sel_fun_q;
  assign bus.sel_acum   = sel_acum_q;
  assign bus.SH_R       = sh_r_q;
  assign bus.Band_Listo = band_listo_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/control_filtro_param.md
# control_filtro_param

Parameterised control sequencer for the FIR filter datapath. It is the next generation of the filter controller: the tap count is set by a parameter and can be trimmed per sample at run time. It adds an async active-low reset, a stall input, back-to-back sample acceptance and overrun reporting. It sits between the sample-ready strobe and the coefficient ROM mux, the function unit and the accumulator. It drives their select lines one tap per clock and raises a one-cycle done flag when the filtered sample is valid.

## Interface
- NTAPS, 5, maximum number of taps sequenced per sample (1..2^SEL_W).
- SEL_W, 3, width of the coefficient select; 2^SEL_W >= NTAPS is required.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- Bandera  input  1  sample-ready strobe; sampled high on a rising edge requests one filter pass.
- n_taps  input  SEL_W+1  taps for this pass; latched only when Bandera is accepted.
- hold  input  1  stall; freezes the sequence while high.
- sel_const  output  SEL_W  coefficient/tap index.
- sel_fun  output  2  function select: 00 idle, 01 multiply, 10 multiply-accumulate.
- sel_acum  output  2  accumulator select: 00 hold, 01 load, 10 accumulate.
- SH_R  output  1  delay-line shift strobe.
- Band_Listo  output  1  one-cycle pulse; the filtered sample is valid.
- busy  output  1  high from the first tap cycle through the SHIFT cycle.
- overrun  output  1  one-cycle pulse; Bandera arrived while busy and was dropped.

## Operation
- All outputs are registered (Moore), and each output value is a function of the state.
- The reset value of every output is 0, and the state resets to IDLE.
- Latching n_taps:
  - 0 is latched as 1.
  - A value above NTAPS is clamped to NTAPS.
  - The latched value is called N.
- States and outputs:
  - IDLE: all outputs 0.
  - FIRST: sel_const=0, sel_fun=01, sel_acum=01, busy=1.
  - ACC: sel_const=k with k=1..N-1, sel_fun=10, sel_acum=10, busy=1.
  - SHIFT: sel_fun=00, sel_acum=00, SH_R=1, busy=1.
  - DONE: Band_Listo=1 and all other outputs 0.
- Transitions:
  - IDLE goes to FIRST on Bandera; otherwise it stays in IDLE.
  - FIRST goes to ACC (k=1) when N>1, or to SHIFT when N=1.
  - ACC increments k each cycle; it goes to SHIFT after k=N-1.
  - SHIFT goes to DONE.
  - DONE goes to FIRST on Bandera (back-to-back, new n_taps latched); otherwise it goes to IDLE.
- Stall: hold=1 in FIRST, ACC or SHIFT freezes the state and tap counter.
  - During the stall, sel_acum is forced to 00 and SH_R to 0, so no double accumulation or shift occurs.
  - sel_const and sel_fun keep their values.
  - hold has no effect in IDLE or DONE.
- Overrun: Bandera high in FIRST, ACC or SHIFT is ignored and pulses overrun on the next cycle. The current pass is not disturbed.
- Reset mid-pass forces IDLE outputs immediately (asynchronously). No partial Band_Listo is produced.

## Timing
- Bandera is sampled at edge 0, and FIRST is visible after edge 0.
- Without stalls, Band_Listo is high in cycle N+2 after the accepting edge. A pass occupies N+2 cycles: N tap cycles, SHIFT and DONE.
- Maximum sustained rate is one sample per N+2 cycles, with Bandera asserted during DONE.
- Each stall cycle adds exactly one cycle of latency.
- sel_const counts 0,1,..,N-1 with no gaps or repeats, including across stalls. It never exceeds NTAPS-1.
- rst_n deassertion is synchronised by the system. The first Bandera after release is honoured on the first edge.

## Test plan
- Basic pass: NTAPS=5, n_taps=5, single Bandera pulse.
  - Required response: sel_const 0,1,2,3,4, then SHIFT, then Band_Listo high exactly 7 cycles after acceptance.
  - sel_acum sequence: 01,10,10,10,10,00.
- Clamping: n_taps=0 runs one tap (FIRST then SHIFT, Band_Listo at cycle 3). n_taps=7 runs 5 taps.
- Stall: hold high for 3 cycles during ACC at k=2.
  - Required response: sel_const stays at 2, sel_acum=00 while held, Band_Listo delayed by 3 cycles.
  - The accumulate count totals N-1.
- Back-to-back and overrun: Bandera high during DONE starts a new pass the next cycle with the newly latched n_taps.
  - Bandera during ACC gives overrun=1 for one cycle, and the pass completes unchanged.
- Reset mid-pass: drop rst_n during ACC at k=3.
  - Required response: all outputs 0 immediately, no Band_Listo, and the next Bandera starts cleanly at sel_const=0.
